wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
Two-master, one-slave Wishbone classic arbiter. It shares the EBR-system peripheral bus (wishbone register, dynamic-latency register) between the midgetv core (m0) and a second master (m1, e.g. a loader or DMA engine). It does round-robin grant, holds the grant for a full CYC, and routes ACK/DAT back only to the granted master. An optional watchdog terminates stalled slave cycles.

Parameters:
TIMEOUT_CYCLES, 64, slave cycles without ACK before a forced termination (watchdog build only); legal range 2..255.
CNTW, 8, width of the watchdog counter; must satisfy 2^CNTW > TIMEOUT_CYCLES.

Ports:
CLK_I  in  1  clock
RST_N_I  in  1  reset, asynchronous, active-low
M0_CYC_I, M0_STB_I, M0_WE_I  in  1 each  master 0 control
M0_ADR_I  in  32  master 0 address
M0_DAT_I  in  32  master 0 write data
M0_SEL_I  in  4  master 0 byte selects
M0_ACK_O  out  1  master 0 acknowledge
M0_DAT_O  out  32  master 0 read data
M1_* (CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, ACK_O, DAT_O)  same widths as M0_*  master 1
S_CYC_O, S_STB_O, S_WE_O  out  1 each  slave control
S_ADR_O  out  32  slave address
S_DAT_O  out  32  slave write data
S_SEL_O  out  4  slave byte selects
S_ACK_I  in  1  slave acknowledge
S_DAT_I  in  32  slave read data
gnt  out  2  one-hot current grant, 00 = idle
tmo_err  out  1  sticky watchdog flag (watchdog build only, else tied 0)

Behaviour:
- Clock CLK_I. Reset RST_N_I is asynchronous and active-low. All state registers clear on RST_N_I=0 without a clock.
- Reset values: gnt=00, state IDLE, priority pointer favours m0, tmo_err=0, counter=0. S_CYC_O, S_STB_O and both ACK_O are 0 during and after reset.
- FSM states:
  - IDLE: if exactly one Mx_CYC_I=1, go to GNTx. If both are 1, grant the master the pointer favours.
  - GNTx: stay while Mx_CYC_I=1. When Mx_CYC_I=0, go to IDLE and point priority at the other master.
  - No direct GNT0->GNT1 transition. There is always at least one IDLE cycle between tenures.
- Latency: a request seen in IDLE at edge n is granted at edge n+1. The slave sees STB from cycle n+1. Grant is registered; the slave-side mux is driven from the registered grant only.
- Slave mux in GNTx:
  - S_CYC_O=Mx_CYC_I, S_STB_O=Mx_STB_I.
  - S_WE_O, S_ADR_O, S_DAT_O and S_SEL_O copy master x.
  - In IDLE, all slave outputs are 0.
- Return path:
  - Mx_ACK_O = S_ACK_I & gnt[x] & Mx_STB_I (combinational).
  - Mx_DAT_O = S_DAT_I when gnt[x], else 0.
  - The non-granted master never sees ACK.
- Multiple back-to-back STB within one CYC tenure are passed through. The arbiter never preempts a tenure.
- A master dropping CYC mid-STB aborts its tenure. The FSM goes to IDLE next edge and a late S_ACK_I is discarded.
- Requests are level-sensitive. A master keeping CYC high is re-granted after IDLE only if the other master is not requesting.

Optional Feature:
Macro WBARB_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle with S_STB_O=1 & S_ACK_I=0, and clears on ACK, on STB low, or in IDLE.
  - When the counter equals TIMEOUT_CYCLES-1 and no ACK has arrived, the arbiter forces a one-cycle termination: Mx_ACK_O=1, Mx_DAT_O=32'hDEAD_BEEF, S_STB_O forced 0 in that cycle.
  - tmo_err is set and stays set until reset.
  - The counter saturates and never wraps.
- Not defined: no counter exists, no forced ACK occurs, and tmo_err is constant 0.

Test Plan:
- Reset: hold RST_N_I=0 asynchronously mid-GNT0 -> same cycle gnt=00, S_CYC_O=0, M0_ACK_O=0; after release, first request from m0 is granted one edge later.
- Single master: m0 reads ADR=32'h6000_0004, slave ACKs after 3 cycles with 32'h1234_5678 -> M0_DAT_O=32'h1234_5678, M0_ACK_O pulse 1 cycle, M1_ACK_O stays 0.
- Simultaneous request from reset: m0 and m1 raise CYC on the same edge -> gnt=01. m0 drops CYC -> one IDLE cycle, then gnt=10.
- Fairness: both masters request continuously for 6 tenures -> grant sequence 01,10,01,10,01,10 with one IDLE cycle between tenures.
- Abort: m1 drops CYC while STB is pending and the slave ACKs a cycle later -> M1_ACK_O=0, gnt=00 next edge.
- WBARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ACKs -> M0_ACK_O=1 with DAT 32'hDEAD_BEEF on cycle 16 of STB, tmo_err=1 thereafter. Without the macro the bus hangs and tmo_err=0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held for a full CYC.
// Define WBARB_TIMEOUT_EN to build the slave-stall watchdog (forced ACK + sticky tmo_err).
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNTW           = 8
) (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  input  logic [3:0]  M0_SEL_I,
  output logic        M0_ACK_O,
  output logic [31:0] M0_DAT_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  input  logic [3:0]  M1_SEL_I,
  output logic        M1_ACK_O,
  output logic [31:0] M1_DAT_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  output logic [3:0]  S_SEL_O,
  input  logic        S_ACK_I,
  input  logic [31:0] S_DAT_I,
  output logic [1:0]  gnt,
  output logic        tmo_err
);

  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  // Reject watchdog settings the counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 ||
      (64'(1) << CNTW) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("wb_arbiter2: illegal TIMEOUT_CYCLES/CNTW combination");
  end

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;   // 0: favour m0, 1: favour m1
  logic   tmo_fire;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Grant only from IDLE; a released tenure hands priority to the other master.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    unique case (state)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I) state_nxt = prio ? GNT1 : GNT0;
        else if (M0_CYC_I)        state_nxt = GNT0;
        else if (M1_CYC_I)        state_nxt = GNT1;
      end
      GNT0: begin
        if (!M0_CYC_I) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b1;
        end
      end
      GNT1: begin
        if (!M1_CYC_I) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt = state;

`ifdef WBARB_TIMEOUT_EN
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  logic [CNTW-1:0] cnt;
  logic            stb_sel;
  logic            tmo_q;

  assign stb_sel  = (state == GNT0) ? M0_STB_I :
                    (state == GNT1) ? M1_STB_I : 1'b0;
  assign tmo_fire = stb_sel && !S_ACK_I && (cnt == CNT_LAST);

  // Counts stalled strobe cycles; saturates rather than wrapping.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      cnt <= '0;
    end else if (state == IDLE || !S_STB_O || S_ACK_I) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I)      tmo_q <= 1'b0;
    else if (tmo_fire) tmo_q <= 1'b1;
  end

  assign tmo_err = tmo_q;
`else
  assign tmo_fire = 1'b0;
  assign tmo_err  = 1'b0;
`endif

  // Slave mux and return path, driven from the registered grant only.
  always_comb begin
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_SEL_O  = '0;
    M0_ACK_O = 1'b0;
    M0_DAT_O = '0;
    M1_ACK_O = 1'b0;
    M1_DAT_O = '0;
    unique case (state)
      GNT0: begin
        S_CYC_O  = M0_CYC_I;
        S_STB_O  = M0_STB_I && !tmo_fire;
        S_WE_O   = M0_WE_I;
        S_ADR_O  = M0_ADR_I;
        S_DAT_O  = M0_DAT_I;
        S_SEL_O  = M0_SEL_I;
        M0_ACK_O = (S_ACK_I && M0_STB_I) || tmo_fire;
        M0_DAT_O = tmo_fire ? TMO_DATA : S_DAT_I;
      end
      GNT1: begin
        S_CYC_O  = M1_CYC_I;
        S_STB_O  = M1_STB_I && !tmo_fire;
        S_WE_O   = M1_WE_I;
        S_ADR_O  = M1_ADR_I;
        S_DAT_O  = M1_DAT_I;
        S_SEL_O  = M1_SEL_I;
        M1_ACK_O = (S_ACK_I && M1_STB_I) || tmo_fire;
        M1_DAT_O = tmo_fire ? TMO_DATA : S_DAT_I;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: vector table for arbitration/routing plus
// hand sequences for reset, fairness, abort and the stalled-slave case.
module tb_wb_arbiter2;

  localparam logic [31:0] M0_ADR = 32'h6000_0004;
  localparam logic [31:0] M1_ADR = 32'h7000_0008;
  localparam logic [31:0] M0_WD  = 32'hA0A0_0000;
  localparam logic [31:0] M1_WD  = 32'hB1B1_1111;
  localparam logic [31:0] RD     = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
  logic        tmo_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT_CYCLES(16), .CNTW(8)) dut (
    .CLK_I(clk), .RST_N_I(rst_n),
    .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
    .M0_DAT_I(m0_wdat), .M0_SEL_I(m0_sel), .M0_ACK_O(m0_ack), .M0_DAT_O(m0_rdat),
    .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
    .M1_DAT_I(m1_wdat), .M1_SEL_I(m1_sel), .M1_ACK_O(m1_ack), .M1_DAT_O(m1_rdat),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr),
    .S_DAT_O(s_wdat), .S_SEL_O(s_sel), .S_ACK_I(s_ack), .S_DAT_I(s_rdat),
    .gnt(gnt), .tmo_err(tmo_err)
  );

  typedef struct {
    logic       m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack;
    logic [1:0] gnt;
    logic       s_cyc, s_stb, m0_ack, m1_ack;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1, input logic ack);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] eg;
    rst_n  = 1'b0;
    m0_we  = 1'b0; m0_adr = M0_ADR; m0_wdat = M0_WD; m0_sel = 4'hF;
    m1_we  = 1'b1; m1_adr = M1_ADR; m1_wdat = M1_WD; m1_sel = 4'h3;
    s_rdat = RD;
    drive(0, 0, 0, 0, 0);

    //            m0c  m0s  m1c  m1s  ack   gnt    scyc sstb a0   a1
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01, 1'b1,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01, 1'b1,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 2'b01, 1'b1,1'b1,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 2'b10, 1'b1,1'b1,1'b0,1'b1};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10, 1'b0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 2'b01, 1'b1,1'b1,1'b1,1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_scyc", 32'(s_cyc), 32'h0);
    check("rst_tmo", 32'(tmo_err), 32'h0);
    rst_n = 1'b1;

    // Vector table: single-master read, then m1 favoured after m0 tenure
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].m0_cyc, vecs[i].m0_stb, vecs[i].m1_cyc, vecs[i].m1_stb, vecs[i].s_ack);
      #1;
      eg = vecs[i].gnt;
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(eg));
      check($sformatf("v%0d_scyc", i), 32'(s_cyc), 32'(vecs[i].s_cyc));
      check($sformatf("v%0d_sstb", i), 32'(s_stb), 32'(vecs[i].s_stb));
      check($sformatf("v%0d_m0ack", i), 32'(m0_ack), 32'(vecs[i].m0_ack));
      check($sformatf("v%0d_m1ack", i), 32'(m1_ack), 32'(vecs[i].m1_ack));
      check($sformatf("v%0d_sadr", i), s_adr, eg[0] ? M0_ADR : eg[1] ? M1_ADR : 32'h0);
      check($sformatf("v%0d_swe", i), 32'(s_we), eg[1] ? 32'h1 : 32'h0);
      check($sformatf("v%0d_m0dat", i), m0_rdat, eg[0] ? RD : 32'h0);
      check($sformatf("v%0d_m1dat", i), m1_rdat, eg[1] ? RD : 32'h0);
    end

    // Asynchronous reset in the middle of a GNT0 tenure
    do_reset();
    @(negedge clk);
    drive(1, 1, 0, 0, 0);
    #1 check("ar_pre_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    #1 check("ar_gnt0", 32'(gnt), 32'h1);
    s_ack = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_scyc", 32'(s_cyc), 32'h0);
    check("ar_m0ack", 32'(m0_ack), 32'h0);
    @(negedge clk);
    s_ack = 1'b0;
    rst_n = 1'b1;
    #1 check("ar_rel_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    #1 check("ar_regrant", 32'(gnt), 32'h1);

    // Simultaneous request from reset and round-robin fairness over 6 tenures
    do_reset();
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      drive(1'((k % 6) != 2), 1'((k % 6) != 2), 1'((k % 6) != 5), 1'((k % 6) != 5), 1'b0);
      #1;
      eg = ((k % 3) == 0) ? 2'b00 : (((k % 6) < 3) ? 2'b01 : 2'b10);
      check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(eg));
    end

    // Abort: m1 drops CYC with STB still high, slave ACKs one cycle late
    do_reset();
    @(negedge clk);
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    #1 check("ab_gnt1", 32'(gnt), 32'h2);
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    #1;
    check("ab_drop_gnt", 32'(gnt), 32'h2);
    check("ab_drop_scyc", 32'(s_cyc), 32'h0);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    check("ab_gnt", 32'(gnt), 32'h0);
    check("ab_m1ack", 32'(m1_ack), 32'h0);
    check("ab_m1dat", m1_rdat, 32'h0);
    check("ab_m0ack", 32'(m0_ack), 32'h0);

    // Slave never ACKs a read from m0
    do_reset();
    @(negedge clk);
    drive(1, 1, 0, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      #1;
`ifdef WBARB_TIMEOUT_EN
      if (j == 15) check("to15_m0ack", 32'(m0_ack), 32'h0);
      if (j == 16) begin
        check("to16_m0ack", 32'(m0_ack), 32'h1);
        check("to16_m0dat", m0_rdat, 32'hDEAD_BEEF);
        check("to16_sstb", 32'(s_stb), 32'h0);
        check("to16_tmo", 32'(tmo_err), 32'h0);
      end
      if (j == 17) begin
        check("to17_tmo", 32'(tmo_err), 32'h1);
        check("to17_m0ack", 32'(m0_ack), 32'h0);
      end
`else
      if (j == 16) begin
        check("to16_m0ack", 32'(m0_ack), 32'h0);
        check("to16_sstb", 32'(s_stb), 32'h1);
      end
      if (j == 20) begin
        check("to20_gnt", 32'(gnt), 32'h1);
        check("to20_tmo", 32'(tmo_err), 32'h0);
      end
`endif
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("to_idle_gnt", 32'(gnt), 32'h0);
`ifdef WBARB_TIMEOUT_EN
    check("to_sticky", 32'(tmo_err), 32'h1);
`else
    check("to_sticky", 32'(tmo_err), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
